// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle core bus: word-addressed storage,
// programmable wait states, one-cycle memready/memerr completion strobes.
module mem_responder #(
    parameter int DATA_W      = 48,
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [DATA_W-1:0] adr,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] memdata,
    output logic              memready,
    output logic              memerr,
    output logic [1:0]        state_dbg
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_L  = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              op_write_q;
    logic [IDX_W-1:0]  addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] adr_lo;
    logic              req;
    logic              req_err;
    logic              acc_en;
    logic              acc_write;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] acc_data;
    logic              unused_adr;

    assign adr_lo     = adr[ADDR_W-1:0];
    assign unused_adr = ^adr[DATA_W-1:ADDR_W];
    assign req        = (state == IDLE) && (memread || memwrite);
    assign req_err    = (memread && memwrite) || ({1'b0, adr_lo} >= DEPTH_L);
    assign state_dbg  = state;

    // With zero wait states the access uses the live request on its capture edge;
    // otherwise it uses the captured copy on the last wait edge.
    always_comb begin
        acc_en    = 1'b0;
        acc_write = op_write_q;
        acc_idx   = addr_q;
        acc_data  = wdata_q;
        if (!reset) begin
            acc_en = 1'b0;
        end else if (req && !req_err && (WAIT_CYCLES == 0)) begin
            acc_en    = 1'b1;
            acc_write = memwrite;
            acc_idx   = adr_lo[IDX_W-1:0];
            acc_data  = writedata;
        end else if ((state == WAIT) && (cnt == CNT_ONE)) begin
            acc_en = 1'b1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (acc_en && acc_write) begin
            mem[acc_idx] <= acc_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            memdata    <= '0;
            memready   <= 1'b0;
            memerr     <= 1'b0;
        end else begin
            if (acc_en && !acc_write) begin
                memdata <= mem[acc_idx];
            end
            case (state)
                IDLE: begin
                    memready <= 1'b0;
                    memerr   <= 1'b0;
                    if (req) begin
                        op_write_q <= memwrite;
                        addr_q     <= adr_lo[IDX_W-1:0];
                        wdata_q    <= writedata;
                        if (req_err) begin
                            state    <= RESP;
                            memready <= 1'b1;
                            memerr   <= 1'b1;
                        end else if (WAIT_CYCLES == 0) begin
                            state    <= RESP;
                            memready <= 1'b1;
                        end else begin
                            cnt   <= WAIT_L;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state    <= RESP;
                        memready <= 1'b1;
                        memerr   <= 1'b0;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    memready <= 1'b0;
                    memerr   <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    memready <= 1'b0;
                    memerr   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with zero wait states, one with two,
// both checked against a storage model and an expected-memdata queue.
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        rd [2];
  logic        wr [2];
  logic [47:0] ad [2];
  logic [47:0] wd [2];
  logic [47:0] md [2];
  logic        rdy [2];
  logic        er [2];
  logic [1:0]  st [2];
  int          wc [2] = '{0, 2};

  mem_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .memread(rd[0]), .memwrite(wr[0]), .adr(ad[0]),
    .writedata(wd[0]), .memdata(md[0]), .memready(rdy[0]), .memerr(er[0]), .state_dbg(st[0])
  );

  mem_responder #(.WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .memread(rd[1]), .memwrite(wr[1]), .adr(ad[1]),
    .writedata(wd[1]), .memdata(md[1]), .memready(rdy[1]), .memerr(er[1]), .state_dbg(st[1])
  );

  int total = 0;
  int bad = 0;
  logic [47:0] exp_q[$];
  logic [47:0] mdl [2][256];
  logic [47:0] last_md [2];

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input int s, input logic r, input logic w,
                        input logic [47:0] a, input logic [47:0] d);
    logic err;
    logic [47:0] e;
    int lat;
    bit got;
    int idx;
    idx = int'(a[11:0]);
    err = (r && w) || (idx >= 256);
    if (!err && r) last_md[s] = mdl[s][idx];
    if (!err && w) mdl[s][idx] = d;
    exp_q.push_back(last_md[s]);
    @(negedge clk);
    rd[s] = r; wr[s] = w; ad[s] = a; wd[s] = d;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (rdy[s]) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    rd[s] = 1'b0; wr[s] = 1'b0;
    e = exp_q.pop_front();
    check("ready_seen", 48'(got), 48'd1);
    check("latency", 48'(lat), err ? 48'd0 : 48'(wc[s]));
    check("memerr", 48'(er[s]), 48'(err));
    check("memdata", md[s], e);
    @(posedge clk);
    #1;
    check("ready_pulse_len", 48'(rdy[s]), 48'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] d;
    logic [47:0] a;
    int s;
    int op;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0; last_md[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_memdata", md[i], 48'd0);
      check("rst_memready", 48'(rdy[i]), 48'd0);
      check("rst_memerr", 48'(er[i]), 48'd0);
      check("rst_state", 48'(st[i]), 48'd0);
    end
    @(negedge clk) reset = 1'b1;

    // preload a working set so every later read has known contents
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 16; j++) begin
        d = {16'($urandom), 32'($urandom)};
        do_req(i, 1'b0, 1'b1, 48'(j), d);
      end
      do_req(i, 1'b0, 1'b1, 48'd255, 48'hA5A5_0000_00FF);
    end

    do_req(1, 1'b0, 1'b1, 48'd5, 48'h0000_1234_5678);
    do_req(1, 1'b1, 1'b0, 48'd5, 48'd0);
    do_req(0, 1'b1, 1'b0, 48'd0, 48'd0);
    do_req(0, 1'b1, 1'b0, 48'd1, 48'd0);

    do_req(1, 1'b1, 1'b0, 48'h100, 48'd0);
    do_req(0, 1'b1, 1'b0, 48'hFFF, 48'd0);
    do_req(1, 1'b1, 1'b0, 48'd255, 48'd0);
    do_req(1, 1'b1, 1'b0, 48'hABCD_0000_0005, 48'd0);

    for (int i = 0; i < 2; i++) begin
      do_req(i, 1'b1, 1'b1, 48'd7, 48'hFFFF_FFFF_FFFF);
      do_req(i, 1'b1, 1'b0, 48'd7, 48'd0);
    end

    repeat (40) begin
      s = $urandom_range(0, 1);
      op = $urandom_range(0, 3);
      a = {16'($urandom), 32'($urandom)};
      if ($urandom_range(0, 7) == 0) a[11:0] = 12'($urandom_range(256, 4095));
      else a[11:0] = 12'($urandom_range(0, 15));
      d = {16'($urandom), 32'($urandom)};
      do_req(s, (op != 0), (op == 0) || (op == 3), a, d);
    end

    // asynchronous reset mid-cycle, no clock edge needed
    do_req(1, 1'b1, 1'b0, 48'd5, 48'd0);
    do_req(0, 1'b1, 1'b0, 48'd1, 48'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("async_rst_memdata", md[i], 48'd0);
      check("async_rst_memready", 48'(rdy[i]), 48'd0);
      check("async_rst_state", 48'(st[i]), 48'd0);
      last_md[i] = '0;
    end
    @(negedge clk) reset = 1'b1;

    // reset one edge after capture aborts a pending write
    @(negedge clk);
    wr[1] = 1'b1; ad[1] = 48'd3; wd[1] = 48'hDEAD_BEEF_0003;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("abort_in_wait", 48'(st[1]), 48'd1);
    reset = 1'b0;
    wr[1] = 1'b0;
    #1;
    check("abort_state", 48'(st[1]), 48'd0);
    check("abort_memready", 48'(rdy[1]), 48'd0);
    last_md[0] = '0;
    last_md[1] = '0;
    @(negedge clk) reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("abort_no_ready", 48'(rdy[1]), 48'd0);
    end
    do_req(1, 1'b1, 1'b0, 48'd3, 48'd0);
    do_req(0, 1'b1, 1'b0, 48'd3, 48'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor's multicycle memory bus (memread/memwrite/adr/writedata out of the core, memdata back in).
- Holds a word-addressed 48-bit storage array and services one request at a time after a programmable number of wait states.
- Signals completion with a one-cycle memready strobe, and reports illegal requests on memerr.
- Sits beside the mips core at top level, replacing direct combinational memory hookup.

Parameters:
DATA_W, 48, word width in bits
ADDR_W, 12, number of address bits decoded from adr
DEPTH, 256, implemented words; valid word addresses are 0..DEPTH-1
WAIT_CYCLES, 2, wait states inserted before the access edge (0 allowed)

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
memread  input  1  read request from core
memwrite  input  1  write request from core
adr  input  48  word address; only the least-significant ADDR_W bits are decoded, the upper bits are ignored
writedata  input  48  store data, captured with the request
memdata  output  48  read data returned to core
memready  output  1  one-cycle completion strobe
memerr  output  1  one-cycle error strobe, coincident with memready

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, memdata=0, memready=0, memerr=0, wait counter=0.
  - Storage contents are not cleared.
  - Reset asserted in WAIT aborts the request; a pending write that has not reached its access edge is never performed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - At a rising edge with memread or memwrite high, capture op, adr[low ADDR_W] into addr_q, and writedata into wdata_q.
  - Check the request at capture:
    - error if memread and memwrite are both high;
    - error if addr_q >= DEPTH.
  - Error request: go directly to RESP with err_q=1. No array access occurs and memdata is unchanged.
  - Legal request, WAIT_CYCLES=0: perform the access on this same edge and go to RESP.
  - Legal request, WAIT_CYCLES>0: load counter=WAIT_CYCLES and go to WAIT.
  - No request: stay in IDLE.
- WAIT:
  - Counter decrements each edge.
  - On the edge where counter==1, perform the access and go to RESP.
  - memread/memwrite/adr/writedata are ignored while in WAIT; the captured values are used.
- Access:
  - Read: memdata <= array[addr_q].
  - Write: array[addr_q] <= wdata_q, memdata unchanged.
  - Read-after-write to the same address returns the new data.
- RESP:
  - memready=1 (and memerr=err_q) for exactly this one cycle.
  - Next edge returns unconditionally to IDLE; inputs are not sampled on the RESP edge.
- Latency:
  - With the request captured at edge E0, memready is high in the cycle between edges E0+WAIT_CYCLES and E0+WAIT_CYCLES+1.
  - Errors always take zero wait states: memready is high after E0.
- Handshake rules:
  - The core must drop memread/memwrite in the memready cycle.
  - A request still high once back in IDLE is treated as a new request; there is no deduplication.
- memdata holds its value between read completions, including across writes and errors, so the core may sample it at any time after memready.
- memready and memerr are registered outputs with no combinational path from inputs.

Test Plan:
- Reset: drive reset low mid-simulation -> memdata=0, memready=0, memerr=0 immediately (asynchronous), state IDLE.
- WAIT_CYCLES=2: write 48'h0000_1234_5678 to adr 5, then read adr 5 -> each memready rises exactly 2 edges after capture, lasts 1 cycle, and memdata=48'h0000_1234_5678 after the read.
- WAIT_CYCLES=0: back-to-back reads of addr 0 and 1, requester dropping the request on memready -> each memready appears in the cycle after capture, and the second request is captured 2 edges after the first.
- Out-of-range, DEPTH=256: read adr 12'h100 -> memready=memerr=1 in the cycle after capture; memdata keeps its prior value.
- Illegal request: memread and memwrite both high to adr 7 with writedata 48'hFFFF_FFFF_FFFF -> memerr pulse; a subsequent read of adr 7 returns its old contents.
- Reset mid-write: issue a write to adr 3 with WAIT_CYCLES=2, pulse reset low one edge after capture -> no memready; a subsequent read of adr 3 returns the pre-write value.
